wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256: number of bus cycles the block waits for wbm_ack_i before aborting; legal range 1..65535.
REQ-002 SHALL have port wb_clk_i, input, 1: single clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_sel in 4, cmd_adr in 32, cmd_dat in 32: command request channel.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_dat out 32, rsp_err out 1: response channel.
REQ-006 SHALL have ports wbm_cyc_o out 1, wbm_stb_o out 1, wbm_we_o out 1, wbm_sel_o out 4, wbm_adr_o out 32, wbm_dat_o out 32, wbm_ack_i in 1, wbm_dat_i in 32: Wishbone classic initiator port.

Function
REQ-007 SHALL implement states IDLE, BUS, RESP; cmd_ready = 1 only in IDLE (combinational from state).
REQ-008 SHALL accept a command on a rising edge with cmd_valid & cmd_ready; next cycle: state BUS, wbm_cyc_o = wbm_stb_o = 1, wbm_we_o/sel_o/adr_o/dat_o = registered cmd fields.
REQ-009 SHALL hold all wbm_* outputs stable throughout BUS.
REQ-010 SHALL, on an edge in BUS with wbm_ack_i = 1, deassert cyc/stb on that edge, go to RESP, set rsp_valid = 1, rsp_err = 0, rsp_dat = wbm_dat_i for reads, 0 for writes; single transaction, latency from accept to rsp_valid = ack cycle + 1.
REQ-011 SHALL ignore wbm_ack_i outside BUS.
REQ-012 SHALL keep a 16-bit wait counter, cleared on entry to BUS, incremented each BUS cycle without ack.
REQ-013 SHALL, when counter reaches TIMEOUT-1 with no ack on that edge, deassert cyc/stb, go RESP, rsp_valid = 1, rsp_err = 1, rsp_dat = 0.
REQ-014 SHALL give ack priority over timeout on the same edge (rsp_err = 0).
REQ-015 SHALL hold rsp_valid/rsp_dat/rsp_err stable in RESP until rsp_valid & rsp_ready, then return to IDLE with rsp_valid = 0; a new command is not accepted in that same cycle.
REQ-016 SHALL never assert wbm_stb_o without wbm_cyc_o.

Reset
REQ-017 SHALL on wb_rst_ni = 0 immediately force: state IDLE, wbm_cyc_o = wbm_stb_o = wbm_we_o = 0, wbm_sel_o = 0, wbm_adr_o = wbm_dat_o = 0, rsp_valid = rsp_err = 0, rsp_dat = 0, counter 0; cmd_ready = 0 while in reset.
REQ-018 SHALL abandon any in-flight transaction on reset, with no response generated.
REQ-019 SHALL release reset synchronously to wb_clk_i rising edge; cmd_ready = 1 first cycle after release.

Configuration
REQ-020 SHALL compile the timeout logic (REQ-012..014) only when macro WB_CMD_MASTER_TIMEOUT_EN is defined.
REQ-021 SHALL, without WB_CMD_MASTER_TIMEOUT_EN, wait in BUS indefinitely for ack, tie rsp_err = 0, and instantiate no counter; TIMEOUT is then unused.

Verification
REQ-022 SHALL cover write: cmd we=1 sel=4'hF adr=32'h3000_0000 dat=32'h0000_00A5, slave acks after 2 cycles -> cyc/stb high 3 cycles, wbm_dat_o=32'hA5, rsp_valid with rsp_err=0, rsp_dat=0.
REQ-023 SHALL cover read: cmd we=0 adr=32'h3000_0000, slave returns wbm_dat_i=32'h0000_1234 with ack 1 cycle after stb -> rsp_dat=32'h1234, rsp_err=0.
REQ-024 SHALL cover timeout (macro defined, TIMEOUT=4): no ack -> stb high exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0; ack arriving on the 4th cycle instead -> rsp_err=0.
REQ-025 SHALL cover backpressure: rsp_ready=0 for 5 cycles with cmd_valid held -> rsp fields stable, cmd_ready=0, no second bus cycle until handshake.
REQ-026 SHALL cover reset mid-BUS: wb_rst_ni low while stb=1 -> cyc/stb=0 same cycle, no rsp_valid after release, next command runs normally.
REQ-027 SHALL cover stray ack: wbm_ack_i=1 in IDLE and RESP -> no state or output change.

Source files
------------

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Turns single commands from a valid/ready request channel into Wishbone
// classic single transfers, and returns the outcome on a valid/ready response
// channel. Only one transfer is in flight at a time. The FSM is
// IDLE -> BUS -> RESP -> IDLE.
//
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to build a 16-bit wait
// counter. It aborts a bus cycle that has gone TIMEOUT cycles without
// wbm_ack_i and reports rsp_err = 1. Without the macro the block waits
// forever for ack, and rsp_err is tied low.
//
// Parameters
//   TIMEOUT     bus cycles to wait for ack before aborting (1..65535).
//               Used only when WB_CMD_MASTER_TIMEOUT_EN is defined.
//
// Ports
//   wb_clk_i    clock, all logic on the rising edge
//   wb_rst_ni   asynchronous active-low reset, released synchronously
//   cmd_*       command channel: valid/ready, we, sel[3:0], adr[31:0], dat[31:0]
//   rsp_*       response channel: valid/ready, dat[31:0], err
//   wbm_*       Wishbone classic initiator: cyc, stb, we, sel, adr, dat out;
//               ack and dat in
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int TIMEOUT = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    // cyc and stb always move together, so one flop drives both.
    // This means stb can never be high without cyc.
    logic        cyc_reg, cyc_next;
    logic        we_reg, we_next;
    logic [3:0]  sel_reg, sel_next;
    logic [31:0] adr_reg, adr_next;
    logic [31:0] dat_reg, dat_next;

    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_dat_reg, rsp_dat_next;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        rsp_err_reg, rsp_err_next;
`else
    // TIMEOUT has no effect in this build.
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg     <= IDLE;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            sel_reg       <= 4'd0;
            adr_reg       <= 32'd0;
            dat_reg       <= 32'd0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= 32'd0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            wait_cnt_reg  <= 16'd0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            we_reg        <= we_next;
            sel_reg       <= sel_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_dat_reg   <= rsp_dat_next;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            wait_cnt_reg  <= wait_cnt_next;
            rsp_err_reg   <= rsp_err_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cyc_next       = cyc_reg;
        we_next        = we_reg;
        sel_next       = sel_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_dat_next   = rsp_dat_reg;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        wait_cnt_next  = wait_cnt_reg;
        rsp_err_next   = rsp_err_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                // cmd_ready is high throughout IDLE once out of reset,
                // so cmd_valid alone means a handshake.
                if (cmd_valid) begin
                    state_next = BUS;
                    cyc_next   = 1'b1;
                    we_next    = cmd_we;
                    sel_next   = cmd_sel;
                    adr_next   = cmd_adr;
                    dat_next   = cmd_dat;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    wait_cnt_next = 16'd0;
`endif
                end
            end

            BUS: begin
                // Ack is checked first, so an ack on the final wait cycle
                // still completes without error.
                if (wbm_ack_i) begin
                    state_next     = RESP;
                    cyc_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_dat_next   = we_reg ? 32'd0 : wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_err_next   = 1'b0;
                end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                    state_next     = RESP;
                    cyc_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_dat_next   = 32'd0;
                    rsp_err_next   = 1'b1;
                end else begin
                    wait_cnt_next  = wait_cnt_reg + 16'd1;
`endif
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    rsp_dat_next   = 32'd0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_err_next   = 1'b0;
`endif
                end
            end

            default: begin
                state_next = IDLE;
                cyc_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gating with the reset pin holds cmd_ready low during reset. It rises
    // in the first cycle after release.
    assign cmd_ready = (state_reg == IDLE) && wb_rst_ni;

    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = cyc_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_sel_o = sel_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_dat   = rsp_dat_reg;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_reg;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = 4'd0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_sel  (cmd_sel),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i)
    );

    // One complete transaction. The slave acks in stb cycle ack_delay+1;
    // ack_delay < 0 means it never acks. Expected results come from the
    // transfer rules: the response carries read data or zero, and with
    // timeout enabled an ack later than TIMEOUT cycles is never seen.
    task automatic run_txn(input string name, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input int ack_delay, input logic [31:0] rdata,
                           input int hold, input bit keep_valid);
        bit          timed_out;
        int          exp_cycles;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          stb_cycles;
        int          wait_cnt;
        bit          bus_bad;
        bit          hold_bad;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        timed_out = (ack_delay < 0) || (ack_delay + 1 > TIMEOUT);
`else
        timed_out = 1'b0;
`endif
        exp_cycles = timed_out ? TIMEOUT : ack_delay + 1;
        exp_err    = timed_out;
        exp_dat    = (timed_out || we) ? 32'd0 : rdata;

        // Offer the command
        @(negedge clk);
        wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
        end
        @(posedge clk); #1;
        if (!keep_valid) begin
            // Scramble the command fields; the bus must show the captured ones.
            cmd_valid = 1'b0;
            cmd_we = ~we; cmd_sel = ~sel; cmd_adr = $urandom; cmd_dat = $urandom;
        end

        // Bus phase
        stb_cycles = 0;
        bus_bad    = 1'b0;
        forever begin
            @(negedge clk);
            if (wbm_stb_o !== 1'b1) break;
            stb_cycles++;
            if (stb_cycles > 1000) break;
            if (wbm_cyc_o !== 1'b1 || wbm_we_o !== we || wbm_sel_o !== sel ||
                wbm_adr_o !== adr || wbm_dat_o !== dat || rsp_valid !== 1'b0)
                bus_bad = 1'b1;
            if (ack_delay >= 0 && stb_cycles == ack_delay + 1) begin
                wbm_ack_i = 1'b1; wbm_dat_i = rdata;
            end else begin
                wbm_ack_i = 1'b0; wbm_dat_i = $urandom;
            end
        end
        wbm_ack_i = 1'b0;

        n_cmp++;
        if (stb_cycles != exp_cycles) begin
            n_fail++;
            $display("FAIL %s stb_cycles: got %0d want %0d", name, stb_cycles, exp_cycles);
        end
        n_cmp++;
        if (bus_bad) begin
            n_fail++;
            $display("FAIL %s bus_fields: got unstable/wrong want we=%b sel=%h adr=%h dat=%h",
                     name, we, sel, adr, dat);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_dat !== exp_dat || rsp_err !== exp_err || wbm_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s response: got v=%b d=%h e=%b cyc=%b want v=1 d=%h e=%b cyc=0",
                     name, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, exp_dat, exp_err);
        end

        // Response backpressure, with stray acks that must be ignored
        hold_bad = 1'b0;
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== exp_dat || rsp_err !== exp_err ||
                cmd_ready !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_cyc_o !== 1'b0)
                hold_bad = 1'b1;
        end
        wbm_ack_i = 1'b0;
        n_cmp++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL %s hold: got response/bus changed want stable d=%h e=%b, no bus cycle",
                     name, exp_dat, exp_err);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_handshake: got v=%b rdy=%b stb=%b want v=0 rdy=1 stb=0",
                     name, rsp_valid, cmd_ready, wbm_stb_o);
        end
        $display("txn %s we=%b adr=%h stb_cycles=%0d rsp_dat=%h err=%b",
                 name, we, adr, stb_cycles, rsp_dat, exp_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 ||
            wbm_sel_o !== 4'd0 || wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0 ||
            rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b cyc=%b stb=%b adr=%h v=%b want all zero",
                     cmd_ready, wbm_cyc_o, wbm_stb_o, wbm_adr_o, rsp_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release cmd_ready: got %b want 1", cmd_ready);
        end
        $display("txn reset done");
    endtask

    task automatic test_write();
        run_txn("write", 1'b1, 4'hF, 32'h3000_0000, 32'h0000_00A5, 2, 32'hDEAD_BEEF, 0, 1'b0);
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 1, 32'h0000_1234, 0, 1'b0);
    endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        run_txn("timeout", 1'b0, 4'h3, 32'h3000_0010, 32'h0, -1, 32'h5555_AAAA, 1, 1'b0);
        run_txn("ack_last", 1'b0, 4'h3, 32'h3000_0010, 32'h0, TIMEOUT - 1, 32'h5555_AAAA, 1, 1'b0);
    endtask
`endif

    task automatic test_backpressure();
        run_txn("backpressure", 1'b0, 4'hC, 32'h3000_0020, 32'h1, 0, 32'hCAFE_F00D, 5, 1'b1);
    endtask

    task automatic test_stray_ack();
        bit bad;
        bad = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
            @(negedge clk);
            if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
                bad = 1'b1;
        end
        wbm_ack_i = 1'b0;
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL stray_ack_idle: got a state/output change want none");
        end
        $display("txn stray_ack idle checked");
        // Stray acks during RESP are driven by the hold phase here.
        run_txn("stray_resp", 1'b1, 4'h1, 32'h3000_0030, 32'h77, 0, 32'h0, 3, 1'b0);
    endtask

    task automatic test_reset_mid_bus();
        bit bad;
        int wait_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0040; cmd_dat = 32'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_cnt = 0;
        @(negedge clk);
        while (wbm_stb_o !== 1'b1 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wait_cnt >= 10) begin
            n_fail++;
            $display("FAIL reset_mid_bus: got cyc=%b stb=%b (waited %0d) want 0 0",
                     wbm_cyc_o, wbm_stb_o, wait_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wbm_stb_o !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_no_rsp: got rsp_valid or stb after release want 0");
        end
        $display("txn reset_mid_bus done");
        run_txn("post_reset", 1'b0, 4'h5, 32'h3000_0044, 32'h0, 1, 32'h0BAD_F00D, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            run_txn($sformatf("rand%0d", i), 1'($urandom), 4'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
`else
            run_txn($sformatf("rand%0d", i), 1'($urandom), 4'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 5)), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
`endif
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_backpressure();
        test_stray_ack();
        test_reset_mid_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
